// File: rtl/sort_checker_pkg.sv
// Shared types and constants for the sort checker: FSM state encoding,
// backpressure LFSR constants, statistics counter width and a saturating
// increment helper.
package sort_checker_pkg;

  typedef enum logic [0:0] {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_e;

  // Fibonacci LFSR, polynomial taps 16,14,13,11. With a right-shifting
  // register these taps land on bits 0,2,3,5; the feedback enters at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/sort_checker_if.sv
// Avalon-ST sink bundle feeding the sort checker.
// Handshake: a beat transfers on a rising clock edge exactly when
// snk_valid_i and snk_ready_o are both high; data/sop/eop are only
// meaningful on such a beat and are ignored otherwise. The source may
// present or withdraw a beat on any cycle; ready does not depend on valid.
interface sort_checker_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] snk_data_i;
  logic              snk_startofpacket_i;
  logic              snk_endofpacket_i;
  logic              snk_valid_i;
  logic              snk_ready_o;

  modport master (
    output snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i,
    input  snk_ready_o
  );

  modport slave (
    input  snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i,
    output snk_ready_o
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the backpressure pattern.
module lfsr16
  import sort_checker_pkg::*;
(
  input  logic        clk_i,
  input  logic        arst_n_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift right, feedback from the tapped bits enters at the top
  always_comb begin
    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  end

  // State register, reloads the seed in reset
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) lfsr_q <= LFSR_SEED;
    else           lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/sort_checker.sv
// Packet checker: accumulates length, sum and ordering of each Avalon-ST
// packet and emits a one-cycle result report plus running statistics.
// A sop arriving in the middle of a packet closes the old packet with a
// framing error; if that sop also carries eop, the resulting length-1
// packet waits one cycle in a single-entry pending slot.
module sort_checker
  import sort_checker_pkg::*;
#(
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1),
  localparam int SUM_W       = DWIDTH + LEN_W
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  sort_checker_if.slave    snk,
  input  logic             bp_en_i,
  output logic             res_valid_o,
  output logic [LEN_W-1:0] res_len_o,
  output logic [SUM_W-1:0] res_sum_o,
  output logic             res_order_err_o,
  output logic             res_frame_err_o,
  output logic             res_len_err_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] orphan_cnt_o,
  output state_e           state_o,
  output logic [15:0]      lfsr_o
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  // Reset synchroniser: assert immediately, release two clk_i edges later
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  logic [15:0] lfsr_state;
  lfsr16 u_lfsr (.clk_i(clk_i), .arst_n_i(rst_n), .state_o(lfsr_state));

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [LEN_W-1:0]   len_q, len_d, len_nxt, c0_len, res_len_q, res_len_d;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_nxt, c0_sum, res_sum_q, res_sum_d, data_ext;
  logic [DWIDTH-1:0]  last_q, last_d, pend_data_q, pend_data_d;
  logic               oerr_q, oerr_d, lerr_q, lerr_d, oerr_nxt, lerr_nxt, len_full;
  logic               pend_vld_q, pend_vld_d;
  logic               c0_vld, c0_oerr, c0_ferr, c0_lerr, c1_vld, orphan_inc, rep_vld;
  logic               res_valid_q, res_valid_d, res_oerr_q, res_oerr_d;
  logic               res_ferr_q, res_ferr_d, res_lerr_q, res_lerr_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d, orphan_cnt_q, orphan_cnt_d;
  logic               acc, sop, eop;

  assign acc      = snk.snk_valid_i && ready_q;
  assign sop      = snk.snk_startofpacket_i;
  assign eop      = snk.snk_endofpacket_i;
  assign data_ext = SUM_W'(snk.snk_data_i);

  // Ready is registered; it follows the LFSR only while backpressure is on
  always_comb ready_d = bp_en_i ? lfsr_state[0] : 1'b1;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE_S;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (acc) begin
      case (state_q)
        IDLE_S:  if (sop && !eop) state_d = RECV_S;
        RECV_S:  if (eop)         state_d = IDLE_S;
        default: state_d = IDLE_S;
      endcase
    end
  end

  // Running packet statistics if the current beat is appended to the packet
  always_comb begin
    len_full = (len_q == LEN_MAX);
    len_nxt  = len_full ? len_q : len_q + LEN_ONE;
    lerr_nxt = lerr_q | len_full;
    oerr_nxt = oerr_q | (snk.snk_data_i < last_q);
    sum_nxt  = sum_q + data_ext;
  end

  // FSM outputs: accumulator updates and the packet(s) closed by this beat
  always_comb begin
    len_d = len_q;  sum_d = sum_q;  last_d = last_q;
    oerr_d = oerr_q;  lerr_d = lerr_q;
    c0_vld = 1'b0;  c0_len = LEN_ONE;  c0_sum = data_ext;
    c0_oerr = 1'b0;  c0_ferr = 1'b0;  c0_lerr = 1'b0;
    c1_vld = 1'b0;  orphan_inc = 1'b0;
    if (acc) begin
      if (sop) begin
        if (state_q == RECV_S) begin
          c0_vld = 1'b1;  c0_len = len_q;  c0_sum = sum_q;
          c0_oerr = oerr_q;  c0_lerr = lerr_q;  c0_ferr = 1'b1;
          c1_vld = eop;
        end else begin
          c0_vld = eop;
        end
        len_d = LEN_ONE;  sum_d = data_ext;  last_d = snk.snk_data_i;
        oerr_d = 1'b0;  lerr_d = 1'b0;
      end else if (state_q == IDLE_S) begin
        orphan_inc = 1'b1;
      end else begin
        len_d = len_nxt;  sum_d = sum_nxt;  last_d = snk.snk_data_i;
        oerr_d = oerr_nxt;  lerr_d = lerr_nxt;
        if (eop) begin
          c0_vld = 1'b1;  c0_len = len_nxt;  c0_sum = sum_nxt;
          c0_oerr = oerr_nxt;  c0_lerr = lerr_nxt;
        end
      end
    end
  end

  // Report selection and statistics. A pending packet is only ever set
  // while the FSM returns to IDLE_S, so a beat closing a packet in the
  // same cycle can only be another length-1 packet; it takes the slot.
  always_comb begin
    rep_vld     = pend_vld_q | c0_vld;
    res_valid_d = rep_vld;
    res_len_d   = res_len_q;  res_sum_d  = res_sum_q;
    res_oerr_d  = res_oerr_q; res_ferr_d = res_ferr_q; res_lerr_d = res_lerr_q;
    if (pend_vld_q) begin
      res_len_d  = LEN_ONE;  res_sum_d  = SUM_W'(pend_data_q);
      res_oerr_d = 1'b0;     res_ferr_d = 1'b0;  res_lerr_d = 1'b0;
    end else if (c0_vld) begin
      res_len_d  = c0_len;   res_sum_d  = c0_sum;
      res_oerr_d = c0_oerr;  res_ferr_d = c0_ferr;  res_lerr_d = c0_lerr;
    end
    pend_vld_d   = pend_vld_q ? c0_vld : c1_vld;
    pend_data_d  = pend_vld_d ? snk.snk_data_i : pend_data_q;
    pkt_cnt_d    = sat_inc(pkt_cnt_q, rep_vld);
    err_cnt_d    = sat_inc(err_cnt_q, rep_vld && (res_oerr_d || res_ferr_d || res_lerr_d));
    orphan_cnt_d = sat_inc(orphan_cnt_q, orphan_inc);
  end

  // Datapath, result and counter registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;  len_q <= '0;  sum_q <= '0;  last_q <= '0;
      oerr_q <= 1'b0;  lerr_q <= 1'b0;  pend_vld_q <= 1'b0;  pend_data_q <= '0;
      res_valid_q <= 1'b0;  res_len_q <= '0;  res_sum_q <= '0;
      res_oerr_q <= 1'b0;  res_ferr_q <= 1'b0;  res_lerr_q <= 1'b0;
      pkt_cnt_q <= '0;  err_cnt_q <= '0;  orphan_cnt_q <= '0;
    end else begin
      ready_q <= ready_d;  len_q <= len_d;  sum_q <= sum_d;  last_q <= last_d;
      oerr_q <= oerr_d;  lerr_q <= lerr_d;  pend_vld_q <= pend_vld_d;  pend_data_q <= pend_data_d;
      res_valid_q <= res_valid_d;  res_len_q <= res_len_d;  res_sum_q <= res_sum_d;
      res_oerr_q <= res_oerr_d;  res_ferr_q <= res_ferr_d;  res_lerr_q <= res_lerr_d;
      pkt_cnt_q <= pkt_cnt_d;  err_cnt_q <= err_cnt_d;  orphan_cnt_q <= orphan_cnt_d;
    end
  end

  assign snk.snk_ready_o  = ready_q;
  assign res_valid_o      = res_valid_q;
  assign res_len_o        = res_len_q;
  assign res_sum_o        = res_sum_q;
  assign res_order_err_o  = res_oerr_q;
  assign res_frame_err_o  = res_ferr_q;
  assign res_len_err_o    = res_lerr_q;
  assign pkt_cnt_o        = pkt_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign orphan_cnt_o     = orphan_cnt_q;
  assign state_o          = state_q;
  assign lfsr_o           = lfsr_state;

endmodule

// File: tb/tb_sort_checker.sv
// Bench for sort_checker: two instances (MAX_PKT_LEN 1024 and 4) share
// one stimulus stream; a packet-level model predicts every report.
module tb_sort_checker;
  import sort_checker_pkg::*;

  localparam int DW   = 8;
  localparam int MAXA = 1024;
  localparam int MAXB = 4;
  localparam int LWA  = $clog2(MAXA + 1);
  localparam int SWA  = DW + LWA;
  localparam int LWB  = $clog2(MAXB + 1);
  localparam int SWB  = DW + LWB;

  logic clk;
  logic arst_n;
  logic bp_en;

  sort_checker_if #(.DWIDTH(DW)) if_a ();
  sort_checker_if #(.DWIDTH(DW)) if_b ();

  logic           res_valid_a, res_oe_a, res_fe_a, res_le_a;
  logic [LWA-1:0] res_len_a;
  logic [SWA-1:0] res_sum_a;
  logic [15:0]    pkt_a, err_a, orph_a, lfsr_a;
  state_e         st_a;
  logic           res_valid_b, res_oe_b, res_fe_b, res_le_b;
  logic [LWB-1:0] res_len_b;
  logic [SWB-1:0] res_sum_b;
  logic [15:0]    pkt_b, err_b, orph_b, lfsr_b;
  state_e         st_b;

  sort_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXA)) u_dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .snk(if_a), .bp_en_i(bp_en),
    .res_valid_o(res_valid_a), .res_len_o(res_len_a), .res_sum_o(res_sum_a),
    .res_order_err_o(res_oe_a), .res_frame_err_o(res_fe_a), .res_len_err_o(res_le_a),
    .pkt_cnt_o(pkt_a), .err_cnt_o(err_a), .orphan_cnt_o(orph_a),
    .state_o(st_a), .lfsr_o(lfsr_a)
  );

  sort_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXB)) u_dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .snk(if_b), .bp_en_i(bp_en),
    .res_valid_o(res_valid_b), .res_len_o(res_len_b), .res_sum_o(res_sum_b),
    .res_order_err_o(res_oe_b), .res_frame_err_o(res_fe_b), .res_len_err_o(res_le_b),
    .pkt_cnt_o(pkt_b), .err_cnt_o(err_b), .orphan_cnt_o(orph_b),
    .state_o(st_b), .lfsr_o(lfsr_b)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  logic [50:0] exp_a_q[$];
  logic [50:0] exp_b_q[$];
  logic [50:0] vis_a, vis_b;
  logic        vld_a, vld_b;
  logic [15:0] m_pkt_a, m_err_a, m_pkt_b, m_err_b, m_orph;
  logic [15:0] m_lfsr;
  logic        m_ready;
  bit          m_in_pkt;
  logic [7:0]  cur_q[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Report for the words collected so far: {len, sum, order, frame, len_err}
  function automatic logic [50:0] mk_rep(input int maxl, input int sw, input bit fe);
    longint s;
    bit     oe;
    int     n;
    int     l;
    s  = 0;
    oe = 1'b0;
    n  = cur_q.size();
    for (int i = 0; i < n; i++) begin
      s = s + longint'(cur_q[i]);
      if (i > 0 && cur_q[i] < cur_q[i-1]) oe = 1'b1;
    end
    s = s % (longint'(1) << sw);
    l = (n > maxl) ? maxl : n;
    return {16'(l), 32'(s), oe, fe, (n > maxl)};
  endfunction

  task automatic push_reports(input bit fe);
    exp_a_q.push_back(mk_rep(MAXA, SWA, fe));
    exp_b_q.push_back(mk_rep(MAXB, SWB, fe));
  endtask

  task automatic model_beat(input bit sop, input bit eop, input logic [7:0] d);
    if (sop) begin
      if (m_in_pkt) push_reports(1'b1);
      cur_q.delete();
      cur_q.push_back(d);
      if (eop) begin push_reports(1'b0); m_in_pkt = 1'b0; end
      else m_in_pkt = 1'b1;
    end else if (!m_in_pkt) begin
      m_orph = sat16(m_orph);
    end else begin
      cur_q.push_back(d);
      if (eop) begin push_reports(1'b0); m_in_pkt = 1'b0; end
    end
  endtask

  task automatic model_reset();
    exp_a_q.delete(); exp_b_q.delete(); cur_q.delete();
    vis_a = '0; vis_b = '0; vld_a = 1'b0; vld_b = 1'b0;
    m_pkt_a = '0; m_err_a = '0; m_pkt_b = '0; m_err_b = '0; m_orph = '0;
    m_lfsr = LFSR_SEED; m_ready = 1'b0; m_in_pkt = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all();
    chk("a_ready",  64'(if_a.snk_ready_o), 64'(m_ready));
    chk("b_ready",  64'(if_b.snk_ready_o), 64'(m_ready));
    chk("lfsr",     64'(lfsr_a), 64'(m_lfsr));
    chk("a_valid",  64'(res_valid_a), 64'(vld_a));
    chk("a_fields", 64'({16'(res_len_a), 32'(res_sum_a), res_oe_a, res_fe_a, res_le_a}), 64'(vis_a));
    chk("a_pkt",    64'(pkt_a), 64'(m_pkt_a));
    chk("a_err",    64'(err_a), 64'(m_err_a));
    chk("a_orph",   64'(orph_a), 64'(m_orph));
    chk("a_state",  64'(st_a), 64'(m_in_pkt ? RECV_S : IDLE_S));
    chk("b_valid",  64'(res_valid_b), 64'(vld_b));
    chk("b_fields", 64'({16'(res_len_b), 32'(res_sum_b), res_oe_b, res_fe_b, res_le_b}), 64'(vis_b));
    chk("b_pkt",    64'(pkt_b), 64'(m_pkt_b));
    chk("b_err",    64'(err_b), 64'(m_err_b));
    chk("b_orph",   64'(orph_b), 64'(m_orph));
    chk("b_state",  64'(st_b), 64'(m_in_pkt ? RECV_S : IDLE_S));
  endtask

  // Driver tasks
  task automatic drive(input bit v, input bit s, input bit e, input logic [7:0] d);
    if_a.snk_valid_i = v; if_a.snk_startofpacket_i = s; if_a.snk_endofpacket_i = e; if_a.snk_data_i = d;
    if_b.snk_valid_i = v; if_b.snk_startofpacket_i = s; if_b.snk_endofpacket_i = e; if_b.snk_data_i = d;
  endtask

  // One clock: drive at negedge, advance the model, check at the next negedge
  task automatic cycle(input bit v, input bit s, input bit e, input logic [7:0] d, output bit acc);
    drive(v, s, e, d);
    acc = v && m_ready;
    if (acc) model_beat(s, e, d);
    m_ready = bp_en ? m_lfsr[0] : 1'b1;
    m_lfsr  = lfsr_step(m_lfsr);
    @(posedge clk);
    @(negedge clk);
    if (exp_a_q.size() > 0) begin
      vis_a = exp_a_q.pop_front(); vld_a = 1'b1;
      m_pkt_a = sat16(m_pkt_a);
      if (|vis_a[2:0]) m_err_a = sat16(m_err_a);
    end else vld_a = 1'b0;
    if (exp_b_q.size() > 0) begin
      vis_b = exp_b_q.pop_front(); vld_b = 1'b1;
      m_pkt_b = sat16(m_pkt_b);
      if (|vis_b[2:0]) m_err_b = sat16(m_err_b);
    end else vld_b = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)), acc);
  endtask

  // Offers each word until accepted; returns on the cycle after the last accept
  task automatic send_pkt(input logic [7:0] w[$], input bit with_sop, input bit with_eop);
    for (int i = 0; i < w.size(); i++) begin
      bit acc;
      int tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        cycle(1'b1, with_sop && (i == 0), with_eop && (i == w.size() - 1), w[i], acc);
        tries++;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    end
  endtask

  // Reset: check the reset state, release, then align the LFSR model to
  // the first cycle ready rises out of reset.
  task automatic do_reset();
    bit seen;
    arst_n = 1'b0;
    bp_en  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    arst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (if_a.snk_ready_o === 1'b1) seen = 1'b1;
    end
    chk("rst_release", 64'(seen), 64'(1));
    m_lfsr  = lfsr_step(LFSR_SEED);
    m_ready = 1'b1;
    check_all();
  endtask

  task automatic random_run(input int n);
    bit         acc, v, s, e;
    logic [7:0] d, last_d;
    int         t;
    last_d = 8'h00;
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 19) == 0) bp_en = ~bp_en;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      e = ($urandom_range(0, 4) == 0);
      if (s) d = 8'($urandom_range(0, 60));
      else if ($urandom_range(0, 7) == 0) d = 8'($urandom_range(0, 255));
      else begin
        t = int'(last_d) + int'($urandom_range(0, 12));
        d = (t > 255) ? 8'hFF : 8'(t);
      end
      cycle(v, s, e, d, acc);
      if (acc) last_d = d;
    end
    bp_en = 1'b0;
    idle(3);
  endtask

  // Directed and random sequence
  initial begin
    logic [7:0] pkt[$];
    arst_n = 1'b0;
    bp_en  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    do_reset();

    // Sorted packet with a repeated word
    pkt = '{8'd3, 8'd5, 8'd5, 8'd9};
    send_pkt(pkt, 1'b1, 1'b1);
    chk("r032_valid", 64'(res_valid_a), 64'(1));
    chk("r032_len",   64'(res_len_a), 64'(4));
    chk("r032_sum",   64'(res_sum_a), 64'(22));
    chk("r032_flags", 64'({res_oe_a, res_fe_a, res_le_a}), 64'(0));
    chk("r032_pkt",   64'(pkt_a), 64'(1));
    idle(1);
    chk("r032_pulse", 64'(res_valid_a), 64'(0));

    // Descending step
    pkt = '{8'd7, 8'd2, 8'd8};
    send_pkt(pkt, 1'b1, 1'b1);
    chk("r033_oerr", 64'(res_oe_a), 64'(1));
    chk("r033_len",  64'(res_len_a), 64'(3));
    chk("r033_sum",  64'(res_sum_a), 64'(17));
    chk("r033_errc", 64'(err_a), 64'(1));
    idle(2);

    // Missing eop, then a single-word packet
    pkt = '{8'd1, 8'd2};
    send_pkt(pkt, 1'b1, 1'b0);
    pkt = '{8'd4};
    send_pkt(pkt, 1'b1, 1'b1);
    chk("r034_ferr", 64'(res_fe_a), 64'(1));
    chk("r034_len1", 64'(res_len_a), 64'(2));
    chk("r034_sum1", 64'(res_sum_a), 64'(3));
    idle(1);
    chk("r034_vld2",  64'(res_valid_a), 64'(1));
    chk("r034_len2",  64'(res_len_a), 64'(1));
    chk("r034_sum2",  64'(res_sum_a), 64'(4));
    chk("r034_flag2", 64'({res_oe_a, res_fe_a, res_le_a}), 64'(0));
    idle(2);

    // Over-length packet on the MAX_PKT_LEN=4 instance
    pkt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    send_pkt(pkt, 1'b1, 1'b1);
    chk("r035_len",  64'(res_len_b), 64'(4));
    chk("r035_lerr", 64'(res_le_b), 64'(1));
    chk("r035_sum",  64'(res_sum_b), 64'(15));
    idle(2);

    // Long packet under backpressure
    bp_en = 1'b1;
    pkt.delete();
    for (int i = 0; i < 256; i++) pkt.push_back(8'(i));
    send_pkt(pkt, 1'b1, 1'b1);
    chk("r036_len",   64'(res_len_a), 64'(256));
    chk("r036_sum",   64'(res_sum_a), 64'(32640));
    chk("r036_flags", 64'({res_oe_a, res_fe_a, res_le_a}), 64'(0));
    bp_en = 1'b0;
    idle(2);

    // Reset in the middle of a packet
    pkt = '{8'd5, 8'd6};
    send_pkt(pkt, 1'b1, 1'b0);
    do_reset();
    chk("r037_valid", 64'(res_valid_a), 64'(0));
    chk("r037_pkt0",  64'(pkt_a), 64'(0));
    pkt = '{8'd1};
    send_pkt(pkt, 1'b1, 1'b1);
    chk("r037_len", 64'(res_len_a), 64'(1));
    chk("r037_pkt", 64'(pkt_a), 64'(1));
    idle(2);

    random_run(800);
    do_reset();
    random_run(800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
